// File: rtl/rvb_bmatinv_pkg.sv
// rvb_bmatinv_pkg: shared constants and state type for the GF(2) bit-matrix inverter
package rvb_bmatinv_pkg;
    localparam logic [63:0] BMAT_IDENTITY = 64'h8040201008040201;
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE = 4'd0;
    localparam state_t ST_DONE = 4'd9;
endpackage

// File: rtl/rvb_bmatinv_step.sv
// rvb_bmatinv_step: one Gauss-Jordan column step on the augmented pair (A, R)
module rvb_bmatinv_step
    import rvb_bmatinv_pkg::*;
(
    input  logic [63:0] i_a,
    input  logic [63:0] i_r,
    input  logic [2:0]  i_col,
    input  logic        i_sing,
    output logic [63:0] o_a,
    output logic [63:0] o_r,
    output logic        o_sing
);
    logic       w_found;
    logic [2:0] w_p;
    logic [7:0] w_ra [8];
    logic [7:0] w_rr [8];
    logic [7:0] w_pa, w_pr;

    always_comb begin
        w_found = 1'b0;
        w_p = i_col;
        for (int i = 7; i >= 0; i--) begin
            if (i >= int'(i_col) && i_a[8*i + int'(i_col)]) begin
                w_found = 1'b1;
                w_p = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            w_ra[i] = i_a[8*i +: 8];
            w_rr[i] = i_r[8*i +: 8];
        end
        if (w_found) begin
            w_ra[i_col] = i_a[8*w_p +: 8];
            w_ra[w_p] = i_a[8*i_col +: 8];
            w_rr[i_col] = i_r[8*w_p +: 8];
            w_rr[w_p] = i_r[8*i_col +: 8];
        end
        w_pa = w_ra[i_col];
        w_pr = w_rr[i_col];
        // the pivot row itself is never touched, so reading it after other rows change is safe
        for (int i = 0; i < 8; i++) begin
            if (w_found && 3'(i) != i_col && w_ra[i][i_col]) begin
                w_ra[i] = w_ra[i] ^ w_pa;
                w_rr[i] = w_rr[i] ^ w_pr;
            end
        end
        o_a = '0;
        o_r = '0;
        for (int i = 0; i < 8; i++) begin
            o_a[8*i +: 8] = w_ra[i];
            o_r[8*i +: 8] = w_rr[i];
        end
        o_sing = i_sing | ~w_found;
    end
endmodule

// File: rtl/rvb_bmatinv.sv
// rvb_bmatinv: 8x8 GF(2) bit-matrix inverter with singular flag and valid/ready handshake
module rvb_bmatinv
    import rvb_bmatinv_pkg::*;
#(
    parameter int CYCLES = 8
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [63:0] din_rs1,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [63:0] dout_rd,
    output logic        dout_singular
);
    if (CYCLES == 8) begin : g_seq
        state_t      r_state, w_next;
        logic [63:0] r_a, r_r, w_na, w_nr;
        logic        r_sing, w_nsing, w_acc, w_busy;
        logic [2:0]  w_col;

        assign w_col = 3'(r_state - 4'd1);

        rvb_bmatinv_step u_step (
            .i_a(r_a), .i_r(r_r), .i_col(w_col), .i_sing(r_sing),
            .o_a(w_na), .o_r(w_nr), .o_sing(w_nsing)
        );

        assign din_ready = (r_state == ST_IDLE || (r_state == ST_DONE && dout_ready)) && !reset;
        assign dout_valid = r_state == ST_DONE && !reset;
        assign w_acc = din_valid && din_ready;
        assign w_busy = r_state != ST_IDLE && r_state != ST_DONE;

        always_comb begin
            w_next = w_acc ? 4'd1 : w_busy ? r_state + 4'd1 : (dout_valid && dout_ready) ? ST_IDLE : r_state;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_a <= '0;
                r_r <= '0;
                r_sing <= 1'b0;
            end else begin
                r_state <= w_next;
                if (w_acc) begin
                    r_a <= din_rs1;
                    r_r <= BMAT_IDENTITY;
                    r_sing <= 1'b0;
                end else if (w_busy) begin
                    r_a <= w_na;
                    r_r <= w_nr;
                    r_sing <= w_nsing;
                end
            end
        end

        assign dout_rd = (dout_valid && !r_sing) ? r_r : '0;
        assign dout_singular = dout_valid && r_sing;
    end else if (CYCLES == 0) begin : g_comb
        logic [63:0] w_a [9];
        logic [63:0] w_r [9];
        logic        w_s [9];

        assign w_a[0] = din_rs1;
        assign w_r[0] = BMAT_IDENTITY;
        assign w_s[0] = 1'b0;

        for (genvar k = 0; k < 8; k++) begin : g_col
            rvb_bmatinv_step u_step (
                .i_a(w_a[k]), .i_r(w_r[k]), .i_col(3'(k)), .i_sing(w_s[k]),
                .o_a(w_a[k+1]), .o_r(w_r[k+1]), .o_sing(w_s[k+1])
            );
        end

        assign dout_valid = din_valid && !reset;
        assign din_ready = dout_ready && !reset;
        assign dout_rd = w_s[8] ? '0 : w_r[8];
        assign dout_singular = w_s[8];
    end else begin : g_bad
        $error("rvb_bmatinv: CYCLES must be 8 or 0");
    end
endmodule
